dict_fifo_nlane: RTL

Parametrised multi-lane dictionary FIFO for the word decompressor. LANES independent write lanes each own a circular DEPTH-entry ring, overwriting the oldest entry on wrap. All LANES*DEPTH entries are exposed as one flat vector for parallel match/lookup, plus a registered indexed read port. Per-lane fill/valid tracking and a synchronous flush are provided, so dictionary state can be restarted between compressed blocks without a global reset.

---
 rtl/dict_fifo_nlane.sv | 130 +++++++++++++
 1 files changed

// File: rtl/dict_fifo_nlane.sv
// -----------------------------------------------------------------------------
// dict_fifo_nlane
//
// Multi-lane dictionary FIFO for the word decompressor. Each of LANES write
// lanes owns a circular ring of DEPTH entries and overwrites its oldest entry
// once the ring has wrapped. All LANES*DEPTH entries are exposed in parallel
// for match/lookup, and a registered indexed read port returns one entry.
// A synchronous flush restores the preload state between compressed blocks.
//
// Flat entry index k = slot*LANES + lane, so lane slots are interleaved.
//
// Ports:
//   i_clk       clock, rising edge
//   i_reset     synchronous active-low reset
//   i_clear     synchronous flush back to the preload state
//   i_wr        per-lane write strobes
//   i_wdata     per-lane write data, lane l at [l*DATA_WIDTH +: DATA_WIDTH]
//   i_rd_en     indexed read request
//   i_rd_idx    flat index to read
//   o_rd_data   registered read data (0 for an index past the last entry)
//   o_rd_valid  o_rd_data was produced by a read issued last cycle
//   o_data      all entries, entry k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_valid     bit k set once entry k has been written since reset/clear
//   o_fill      per-lane fill count, lane l at [l*CW +: CW]
//   o_full      per-lane full flag (fill == DEPTH)
// -----------------------------------------------------------------------------
module dict_fifo_nlane #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 2,
  parameter int DEPTH      = 8,
  parameter int IDX_W      = $clog2(LANES * DEPTH),
  parameter int CW         = $clog2(DEPTH + 1)
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic                                i_clear,
  input  logic [LANES-1:0]                    i_wr,
  input  logic [LANES*DATA_WIDTH-1:0]         i_wdata,
  input  logic                                i_rd_en,
  input  logic [IDX_W-1:0]                    i_rd_idx,
  output logic [DATA_WIDTH-1:0]               o_rd_data,
  output logic                                o_rd_valid,
  output logic [LANES*DEPTH*DATA_WIDTH-1:0]   o_data,
  output logic [LANES*DEPTH-1:0]              o_valid,
  output logic [LANES*CW-1:0]                 o_fill,
  output logic [LANES-1:0]                    o_full
);

  localparam int ENTRIES = LANES * DEPTH;
  localparam int PW      = $clog2(DEPTH);

  // Packed arrays so the flat output vectors are plain wiring of the state.
  logic [ENTRIES-1:0][DATA_WIDTH-1:0] data_q;
  logic [ENTRIES-1:0]                 valid_q;
  logic [LANES-1:0][PW-1:0]           ptr_q;
  logic [LANES-1:0][CW-1:0]           fill_q;
  logic [LANES-1:0]                   full_q;
  logic [DATA_WIDTH-1:0]              rd_data_q;
  logic                               rd_valid_q;
  logic                               in_range;

  // Preload pattern: the low nibble of the flat index replicated across the word.
  function automatic logic [DATA_WIDTH-1:0] preload(input int k);
    logic [3:0] nib;
    nib = k[3:0];
    return {(DATA_WIDTH / 4){nib}};
  endfunction

  // An out-of-range index only exists when the index space is not exactly filled.
  generate
    if ((1 << IDX_W) > ENTRIES) begin : g_range_check
      assign in_range = (i_rd_idx < IDX_W'(ENTRIES));
    end else begin : g_range_full
      assign in_range = 1'b1;
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (!i_reset || i_clear) begin
      // NOTE: the dictionary must come back to a non-zero preload pattern, so
      // the entries are reset flops rather than an inferable RAM.
      for (int k = 0; k < ENTRIES; k++) begin
        data_q[k] <= preload(k);
      end
      valid_q    <= '0;
      ptr_q      <= '0;
      fill_q     <= '0;
      full_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      // Entry k belongs to lane k%LANES, slot k/LANES; it is written when its
      // lane strobes and that lane's pointer sits on its slot.
      for (int k = 0; k < ENTRIES; k++) begin
        if (i_wr[k % LANES] && (ptr_q[k % LANES] == PW'(k / LANES))) begin
          // NOTE: non-blocking assignments here, so the read below still sees
          // the pre-write contents of an entry written in the same cycle.
          data_q[k]  <= i_wdata[(k % LANES) * DATA_WIDTH +: DATA_WIDTH];
          valid_q[k] <= 1'b1;
        end
      end

      for (int l = 0; l < LANES; l++) begin
        if (i_wr[l]) begin
          // DEPTH is a power of two, so the pointer wraps by overflow.
          ptr_q[l] <= ptr_q[l] + 1'b1;
          if (!full_q[l]) begin
            fill_q[l] <= fill_q[l] + 1'b1;
          end
          if (fill_q[l] == CW'(DEPTH - 1)) begin
            full_q[l] <= 1'b1;
          end
        end
      end

      rd_valid_q <= i_rd_en;
      if (i_rd_en) begin
        rd_data_q <= in_range ? data_q[i_rd_idx] : '0;
      end
    end
  end

  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_fill     = fill_q;
  assign o_full     = full_q;
  assign o_rd_data  = rd_data_q;
  assign o_rd_valid = rd_valid_q;

endmodule
